// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// This package holds the definitions that the hex keypad scanner, the event
// FIFO and the downstream decoders share.
//   KEYPAD_CODE_W   : default key code width.
//   KEYPAD_TSTAMP_W : width of the optional event timestamp.
//   holdoff_state_e : states of the press hold-off FSM.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KEYPAD_CODE_W   = 4;
  localparam int KEYPAD_TSTAMP_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } holdoff_state_e;

endpackage

// File: rtl/keypad_event_fifo_if.sv
// -----------------------------------------------------------------------------
// keypad_event_fifo_if
// This interface bundles the signals of the keypad event FIFO.
//   key_code/key_valid : scanner side, driven by the master.
//   clr_ovf            : clears the sticky overflow flag (master).
//   out_code/out_valid : head of the queue, driven by the slave.
//   out_ready          : consumer acceptance (master).
//   count/overflow     : queue occupancy and sticky drop flag (slave).
//   out_tstamp         : push-cycle timestamp of the head entry. It exists only
//                        when KEYPAD_EVENT_FIFO_TSTAMP_EN is defined.
// The slave modport belongs to keypad_event_fifo. The master modport belongs
// to whatever drives the scanner side and consumes the queue.
// -----------------------------------------------------------------------------
interface keypad_event_fifo_if
  import keypad_pkg::*;
#(
  parameter int CODE_W = KEYPAD_CODE_W,
  parameter int DEPTH  = 8
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              clr_ovf;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic              overflow;

`ifdef KEYPAD_EVENT_FIFO_TSTAMP_EN
  logic [KEYPAD_TSTAMP_W-1:0] out_tstamp;

  modport master (
    output key_code, key_valid, clr_ovf, out_ready,
    input  out_code, out_valid, count, overflow, out_tstamp
  );

  modport slave (
    input  key_code, key_valid, clr_ovf, out_ready,
    output out_code, out_valid, count, overflow, out_tstamp
  );
`else
  modport master (
    output key_code, key_valid, clr_ovf, out_ready,
    input  out_code, out_valid, count, overflow
  );

  modport slave (
    input  key_code, key_valid, clr_ovf, out_ready,
    output out_code, out_valid, count, overflow
  );
`endif

endinterface

// File: rtl/keypad_sync_fifo.sv
// -----------------------------------------------------------------------------
// keypad_sync_fifo
// This is a single-clock FIFO. The pointers are one bit wider than the address
// and wrap modulo 2*DEPTH, and the extra MSB tells full from empty.
//   clock, reset : rising-edge clock, asynchronous active-high reset.
//   push, wdata  : write request and data. The FIFO accepts the write when it
//                  is not full, or when a pop happens in the same cycle.
//   pop          : read request. The FIFO ignores it while empty.
//   rdata        : head entry. It reads as zero while the FIFO is empty.
//   count        : occupancy, wr_ptr - rd_ptr.
//   full, empty  : status flags.
// -----------------------------------------------------------------------------
module keypad_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // When the FIFO is full, a pop in the same cycle frees the slot that the
  // push is about to fill.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The storage is not reset. Reset empties the queue through the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/keypad_event_fifo.sv
// -----------------------------------------------------------------------------
// keypad_event_fifo
// This block turns the keypad scanner's valid strobes into one event per key
// press and queues the key codes for the host.
//   clock, reset : rising-edge clock, asynchronous active-high reset.
//   bus (slave)  : key_code/key_valid from the scanner, clr_ovf,
//                  out_code/out_valid/out_ready toward the consumer,
//                  count (occupancy) and overflow (sticky drop flag).
// The hold-off FSM waits in BLOCK after each accepted strobe. Any further
// strobe restarts the HOLDOFF-cycle quiet window. Only a strobe seen in IDLE
// counts as a new press.
// Optional feature (define KEYPAD_EVENT_FIFO_TSTAMP_EN): a free-running 16-bit
// cycle counter is added. Each entry is stored together with the counter
// value from its push cycle, and that value appears on bus.out_tstamp.
// -----------------------------------------------------------------------------
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CODE_W  = KEYPAD_CODE_W,
  parameter int HOLDOFF = 16
) (
  input  logic                clock,
  input  logic                reset,
  keypad_event_fifo_if.slave  bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

`ifdef KEYPAD_EVENT_FIFO_TSTAMP_EN
  localparam int FIFO_W = CODE_W + KEYPAD_TSTAMP_W;
`else
  localparam int FIFO_W = CODE_W;
`endif

  holdoff_state_e    state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              overflow_q, overflow_d;
  logic              push_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Hold-off FSM
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          push_req = 1'b1;
          hold_d   = HOLD_LOAD;
          state_d  = BLOCK;
        end
      end
      BLOCK: begin
        if (bus.key_valid) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // A full queue implies a non-empty queue, so out_ready alone means a pop
  // is happening this cycle and the push can take the freed slot.
  assign drop = push_req & fifo_full & ~bus.out_ready;

  // If a drop and a clear happen in the same cycle, the drop wins.
  always_comb begin
    overflow_d = drop | (overflow_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

`ifdef KEYPAD_EVENT_FIFO_TSTAMP_EN
  logic [KEYPAD_TSTAMP_W-1:0] tstamp_q, tstamp_d;

  always_comb begin
    tstamp_d = tstamp_q + KEYPAD_TSTAMP_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_d;
    end
  end

  assign fifo_wdata = {tstamp_q, bus.key_code};
  assign bus.out_tstamp = fifo_rdata[FIFO_W-1:CODE_W];
`else
  assign fifo_wdata = bus.key_code;
`endif

  keypad_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (bus.out_ready),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_code  = fifo_rdata[CODE_W-1:0];
  assign bus.out_valid = ~fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
module tb_keypad_event_fifo;

  localparam int DEPTH   = 8;
  localparam int CODE_W  = 4;
  localparam int HOLDOFF = 16;

  logic clock;
  logic reset;

  keypad_event_fifo_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

  keypad_event_fifo #(
    .DEPTH   (DEPTH),
    .CODE_W  (CODE_W),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [15:0]       ts;
  } entry_t;

  entry_t      q[$];
  bit          m_ovf;
  int          low_run;
  logic [15:0] m_ts;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("count", 32'(bus.count), 32'(q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("out_code", 32'(bus.out_code), (q.size() > 0) ? 32'(q[0].code) : 32'd0);
`ifdef KEYPAD_EVENT_FIFO_TSTAMP_EN
    check("out_tstamp", 32'(bus.out_tstamp), (q.size() > 0) ? 32'(q[0].ts) : 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, advance the model at posedge, and
  // compare just after the edge.
  task automatic cycle(input logic kv, input logic [CODE_W-1:0] kc,
                       input logic rdy, input logic clr);
    bit new_press;
    bit pop;
    bit dropped;
    entry_t e;
    @(negedge clock);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.out_ready = rdy;
    bus.clr_ovf   = clr;
    @(posedge clock);
    // A strobe is a new press only after HOLDOFF quiet cycles since the
    // previous strobe, accepted or not.
    new_press = kv && (low_run >= HOLDOFF);
    if (kv) low_run = 0;
    else if (low_run < HOLDOFF) low_run++;
    pop = rdy && (q.size() > 0);
    if (pop) void'(q.pop_front());
    dropped = 1'b0;
    if (new_press) begin
      if (q.size() < DEPTH) begin
        e.code = kc;
        e.ts   = m_ts;
        q.push_back(e);
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_ts = m_ts + 16'd1;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_out_code", 32'(bus.out_code), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    m_ovf   = 1'b0;
    low_run = HOLDOFF;
    m_ts    = 16'd0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    do_reset();

    // Single press
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    check("single_count", 32'(bus.count), 32'd1);
    check("single_code", 32'(bus.out_code), 32'hA);
    idle(1, 1'b1);
    check("single_drained", 32'(bus.count), 32'd0);
    idle(20, 1'b0);

    // Bounce: strobes at 0, 3 and 9, then a new press at 26
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    idle(5, 1'b0);
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    idle(16, 1'b0);
    check("bounce_count", 32'(bus.count), 32'd1);
    check("bounce_code", 32'(bus.out_code), 32'h5);
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    check("bounce_new_press", 32'(bus.count), 32'd2);
    idle(3, 1'b1);
    idle(20, 1'b0);

    // Overflow: nine well-separated presses with no consumer
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, CODE_W'(i), 1'b0, 1'b0);
      idle(17, 1'b0);
    end
    check("ovf_count", 32'(bus.count), 32'd8);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_head", 32'(bus.out_code), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full queue, with a push and a pop in the same cycle
    cycle(1'b1, 4'hF, 1'b1, 1'b0);
    check("full_pushpop_count", 32'(bus.count), 32'd8);
    check("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
    idle(7, 1'b1);
    check("full_last_code", 32'(bus.out_code), 32'hF);
    idle(1, 1'b1);
    check("full_drained", 32'(bus.count), 32'd0);
    idle(20, 1'b0);

    // Reset in the middle of operation
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, CODE_W'(i + 3), 1'b0, 1'b0);
      idle(17, 1'b0);
    end
    check("pre_reset_count", 32'(bus.count), 32'd3);
    do_reset();
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    check("post_reset_count", 32'(bus.count), 32'd1);
    check("post_reset_code", 32'(bus.out_code), 32'h9);
    idle(20, 1'b1);

    // Pointer wrap: 20 presses interleaved with random pops
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, CODE_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 17; k++) cycle(1'b0, '0, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    idle(12, 1'b1);

    // Random traffic with varying strobe density and consumer rate
    for (int blk = 0; blk < 24; blk++) begin
      int pk;
      int pr;
      pk = $urandom_range(2, 20);
      pr = $urandom_range(0, 100);
      if (blk == 12) do_reset();
      for (int c = 0; c < 150; c++) begin
        cycle(1'($urandom_range(0, 99) < pk), CODE_W'($urandom_range(0, 15)),
              1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
